vga_text_console: RTL and testbench

Character-stream terminal engine that sits directly upstream of the VGA text controller's CPU write port. It accepts bytes over a valid/ready handshake and tracks an 80x60 cursor. Printable bytes are written into the text RAM, control codes are interpreted, and a line is blanked whenever the cursor enters it. Its outputs wire one-to-one to the controller's cpu_write_enable / cpu_addr / cpu_char_in.

---
 rtl/vga_text_pkg.sv | 29 ++
 rtl/vga_text_console.sv | 161 ++++++++++++++++
 tb/tb_vga_text_console.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_text_pkg.sv
// Shared constants and types for the VGA text path. The text controller and
// the console engine both take their screen geometry from here.
package vga_text_pkg;

    localparam int CHARS_X      = 80;
    localparam int CHARS_Y      = 60;
    localparam int SCREEN_CELLS = CHARS_X * CHARS_Y;
    localparam int ADDR_W       = 13;

    localparam logic [7:0] BLANK_CHAR = 8'h20;

    // Control codes interpreted by the console
    localparam logic [7:0] LF = 8'h0A;
    localparam logic [7:0] CR = 8'h0D;
    localparam logic [7:0] BS = 8'h08;
    localparam logic [7:0] FF = 8'h0C;

    typedef enum logic [1:0] {
        IDLE,
        CLR_LINE,
        CLR_SCREEN
    } state_t;

    // Bytes that land in text RAM as glyphs rather than being interpreted
    function automatic logic is_printable(input logic [7:0] b);
        return (b >= 8'h20) && (b <= 8'h7E);
    endfunction

endpackage

// File: rtl/vga_text_console.sv
// Character-stream terminal engine feeding the VGA text controller's CPU
// write port. Tracks an 80x60 cursor, writes printable bytes, interprets
// LF/CR/BS/FF and blanks each row as the cursor enters it.
module vga_text_console
    import vga_text_pkg::*;
(
    input  logic              clk_pixel,
    input  logic              rst,
    input  logic              char_valid,
    input  logic [7:0]        char_in,
    output logic              char_ready,
    input  logic              cls_req,
    output logic              cpu_write_enable,
    output logic [ADDR_W-1:0] cpu_addr,
    output logic [7:0]        cpu_char_in,
    output logic [6:0]        cursor_x,
    output logic [5:0]        cursor_y,
    output logic              busy
);

    localparam logic [6:0]        LAST_COL    = 7'(CHARS_X - 1);
    localparam logic [5:0]        LAST_ROW    = 6'(CHARS_Y - 1);
    localparam logic [ADDR_W-1:0] ROW_STRIDE  = ADDR_W'(CHARS_X);
    localparam logic [ADDR_W-1:0] SCREEN_DONE = ADDR_W'(SCREEN_CELLS);

    state_t              state, state_d;
    logic [6:0]          cursor_x_d;
    logic [5:0]          cursor_y_d;
    // cursor_y * CHARS_X, kept by stepping so no multiplier is needed
    logic [ADDR_W-1:0]   row_base, row_base_d;
    logic [ADDR_W-1:0]   clr_cnt, clr_cnt_d;
    logic                we_d;
    logic [ADDR_W-1:0]   addr_d;
    logic [7:0]          data_d;

    logic [ADDR_W-1:0]   cur_addr;
    logic [5:0]          next_row;
    logic [ADDR_W-1:0]   next_row_base;

    // A clear request always wins over a byte offered in the same cycle
    assign char_ready = (state == IDLE) && !cls_req;
    assign busy       = (state != IDLE);

    // Cell under the cursor and the row/base the cursor moves to on a newline
    always_comb begin
        cur_addr      = row_base + ADDR_W'(cursor_x);
        next_row      = (cursor_y == LAST_ROW) ? 6'd0 : cursor_y + 6'd1;
        next_row_base = (cursor_y == LAST_ROW) ? '0 : row_base + ROW_STRIDE;
    end

    // Next-state, cursor movement and write-port values
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned, which would infer a latch.
        state_d    = state;
        cursor_x_d = cursor_x;
        cursor_y_d = cursor_y;
        row_base_d = row_base;
        clr_cnt_d  = clr_cnt;
        we_d       = 1'b0;
        addr_d     = cpu_addr;
        data_d     = cpu_char_in;

        case (state)
            IDLE: begin
                if (cls_req || (char_valid && char_in == FF)) begin
                    state_d    = CLR_SCREEN;
                    clr_cnt_d  = '0;
                    cursor_x_d = '0;
                    cursor_y_d = '0;
                    row_base_d = '0;
                end else if (char_valid) begin
                    if (is_printable(char_in)) begin
                        we_d   = 1'b1;
                        addr_d = cur_addr;
                        data_d = char_in;
                        if (cursor_x == LAST_COL) begin
                            cursor_x_d = '0;
                            cursor_y_d = next_row;
                            row_base_d = next_row_base;
                            clr_cnt_d  = '0;
                            state_d    = CLR_LINE;
                        end else begin
                            cursor_x_d = cursor_x + 7'd1;
                        end
                    end else begin
                        case (char_in)
                            LF: begin
                                cursor_x_d = '0;
                                cursor_y_d = next_row;
                                row_base_d = next_row_base;
                                clr_cnt_d  = '0;
                                state_d    = CLR_LINE;
                            end
                            CR: cursor_x_d = '0;
                            BS: begin
                                // No reverse wrap onto the previous row
                                if (cursor_x != 7'd0) begin
                                    cursor_x_d = cursor_x - 7'd1;
                                    we_d       = 1'b1;
                                    addr_d     = cur_addr - ADDR_W'(1);
                                    data_d     = BLANK_CHAR;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            end

            // One idle cycle after the last blank before accepting bytes again
            CLR_LINE: begin
                if (clr_cnt == ROW_STRIDE) begin
                    state_d = IDLE;
                end else begin
                    we_d      = 1'b1;
                    addr_d    = row_base + clr_cnt;
                    data_d    = BLANK_CHAR;
                    clr_cnt_d = clr_cnt + ADDR_W'(1);
                end
            end

            CLR_SCREEN: begin
                if (clr_cnt == SCREEN_DONE) begin
                    state_d = IDLE;
                end else begin
                    we_d      = 1'b1;
                    addr_d    = clr_cnt;
                    data_d    = BLANK_CHAR;
                    clr_cnt_d = clr_cnt + ADDR_W'(1);
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // State, cursor and registered write port; reset restarts a full clear
    always_ff @(posedge clk_pixel or posedge rst) begin
        if (rst) begin
            state            <= CLR_SCREEN;
            cursor_x         <= '0;
            cursor_y         <= '0;
            row_base         <= '0;
            clr_cnt          <= '0;
            cpu_write_enable <= 1'b0;
            cpu_addr         <= '0;
            cpu_char_in      <= BLANK_CHAR;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            state            <= state_d;
            cursor_x         <= cursor_x_d;
            cursor_y         <= cursor_y_d;
            row_base         <= row_base_d;
            clr_cnt          <= clr_cnt_d;
            cpu_write_enable <= we_d;
            cpu_addr         <= addr_d;
            cpu_char_in      <= data_d;
        end
    end

endmodule

// File: tb/tb_vga_text_console.sv
// Directed self-checking bench for vga_text_console.
module tb_vga_text_console;
    import vga_text_pkg::*;

    logic              clk_pixel = 1'b0;
    logic              rst;
    logic              char_valid;
    logic [7:0]        char_in;
    logic              char_ready;
    logic              cls_req;
    logic              cpu_write_enable;
    logic [ADDR_W-1:0] cpu_addr;
    logic [7:0]        cpu_char_in;
    logic [6:0]        cursor_x;
    logic [5:0]        cursor_y;
    logic              busy;

    int checks = 0;
    int errors = 0;

    vga_text_console dut (
        .clk_pixel        (clk_pixel),
        .rst              (rst),
        .char_valid       (char_valid),
        .char_in          (char_in),
        .char_ready       (char_ready),
        .cls_req          (cls_req),
        .cpu_write_enable (cpu_write_enable),
        .cpu_addr         (cpu_addr),
        .cpu_char_in      (cpu_char_in),
        .cursor_x         (cursor_x),
        .cursor_y         (cursor_y),
        .busy             (busy)
    );

    always #5 clk_pixel = ~clk_pixel;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Offer a byte, wait (bounded) for acceptance; returns at the negedge of cycle N+1
    task automatic send(input logic [7:0] b);
        int waited = 0;
        char_valid = 1'b1;
        char_in    = b;
        while (!char_ready && waited < 6000) begin
            @(negedge clk_pixel);
            waited++;
        end
        if (!char_ready) check("send_ready", char_ready, 1);
        @(posedge clk_pixel);
        @(negedge clk_pixel);
        char_valid = 1'b0;
    endtask

    // Follow a clear until char_ready rises: blank strobes, address errors, low cycles
    task automatic drain(input int start, output int n, output int bad, output int low);
        n = 0; bad = 0; low = 0;
        for (int c = 0; c < 6000; c++) begin
            @(negedge clk_pixel);
            if (char_ready) break;
            low++;
            if (cpu_write_enable) begin
                if (cpu_addr !== ADDR_W'(start + n) || cpu_char_in !== BLANK_CHAR) bad++;
                n++;
            end
        end
        check("drain_ready", char_ready, 1);
    endtask

    initial begin
        int n, bad, low;
        rst = 1'b1; char_valid = 1'b0; char_in = 8'h00; cls_req = 1'b0;
        repeat (3) @(negedge clk_pixel);

        // Reset state
        check("rst_we", cpu_write_enable, 0);
        check("rst_addr", cpu_addr, 0);
        check("rst_data", cpu_char_in, 8'h20);
        check("rst_cx", cursor_x, 0);
        check("rst_cy", cursor_y, 0);
        check("rst_ready", char_ready, 0);
        check("rst_busy", busy, 1);

        // Power-up clear: 4800 blanks at 0..4799 before ready rises
        rst = 1'b0;
        drain(0, n, bad, low);
        check("boot_strobes", n, 4800);
        check("boot_bad", bad, 0);
        check("boot_low", low, 4800);
        check("boot_cx", cursor_x, 0);
        check("boot_cy", cursor_y, 0);
        check("boot_busy", busy, 0);

        // "AB" back to back
        char_valid = 1'b1; char_in = 8'h41;
        @(posedge clk_pixel); @(negedge clk_pixel);
        check("a_we", cpu_write_enable, 1);
        check("a_addr", cpu_addr, 0);
        check("a_data", cpu_char_in, 8'h41);
        check("a_ready", char_ready, 1);
        char_in = 8'h42;
        @(posedge clk_pixel); @(negedge clk_pixel);
        check("b_we", cpu_write_enable, 1);
        check("b_addr", cpu_addr, 1);
        check("b_data", cpu_char_in, 8'h42);
        char_valid = 1'b0;
        @(negedge clk_pixel);
        check("ab_we_drop", cpu_write_enable, 0);
        check("ab_cx", cursor_x, 2);
        check("ab_cy", cursor_y, 0);

        // Unknown control byte is swallowed
        send(8'h01);
        check("ign_we", cpu_write_enable, 0);
        check("ign_cx", cursor_x, 2);

        // Two LFs to (0,2), clearing rows 1 and 2
        send(LF);
        check("lf1_we", cpu_write_enable, 0);
        check("lf1_cy", cursor_y, 1);
        drain(80, n, bad, low);
        check("lf1_strobes", n, 80);
        check("lf1_bad", bad, 0);
        send(LF);
        drain(160, n, bad, low);
        check("lf2_bad", bad, 0);
        check("lf2_cx", cursor_x, 0);
        check("lf2_cy", cursor_y, 2);

        // Backspace from (5,2) blanks cell 164
        for (int i = 0; i < 5; i++) send(8'h78);
        check("pre_bs_cx", cursor_x, 5);
        send(BS);
        check("bs_we", cpu_write_enable, 1);
        check("bs_addr", cpu_addr, 164);
        check("bs_data", cpu_char_in, 8'h20);
        check("bs_cx", cursor_x, 4);
        check("bs_cy", cursor_y, 2);

        // CR then BS at column 0: neither writes
        send(CR);
        check("cr_we", cpu_write_enable, 0);
        check("cr_cx", cursor_x, 0);
        send(BS);
        check("bs0_we", cpu_write_enable, 0);
        check("bs0_cx", cursor_x, 0);
        check("bs0_cy", cursor_y, 2);
        check("bs0_busy", busy, 0);

        // To (79,3), then a character that wraps the line
        send(LF);
        drain(240, n, bad, low);
        check("lf3_bad", bad, 0);
        for (int i = 0; i < 79; i++) send(8'h2E);
        check("pre_wrap_cx", cursor_x, 79);
        check("pre_wrap_cy", cursor_y, 3);
        send(8'h5A);
        check("wrap_we", cpu_write_enable, 1);
        check("wrap_addr", cpu_addr, 319);
        check("wrap_data", cpu_char_in, 8'h5A);
        check("wrap_ready", char_ready, 0);
        check("wrap_cx", cursor_x, 0);
        check("wrap_cy", cursor_y, 4);
        drain(320, n, bad, low);
        check("wrap_strobes", n, 80);
        check("wrap_bad", bad, 0);
        check("wrap_low", low + 1, 81);

        // Walk down to row 59
        for (int r = 5; r < 60; r++) begin
            send(LF);
            drain(r * 80, n, bad, low);
            check("walk_strobes", n, 80);
            check("walk_bad", bad, 0);
        end
        check("walk_cy", cursor_y, 59);

        // LF at (10,59) wraps to row 0 and blanks cells 0..79
        for (int i = 0; i < 10; i++) send(8'h61);
        check("pre_lfw_cx", cursor_x, 10);
        send(LF);
        check("lfw_we", cpu_write_enable, 0);
        check("lfw_cx", cursor_x, 0);
        check("lfw_cy", cursor_y, 0);
        drain(0, n, bad, low);
        check("lfw_strobes", n, 80);
        check("lfw_bad", bad, 0);

        // cls_req beats a simultaneous byte, then reset mid-clear
        send(8'h51);
        check("q_cx", cursor_x, 1);
        cls_req = 1'b1; char_valid = 1'b1; char_in = 8'h57;
        #1;
        check("cls_ready", char_ready, 0);
        @(posedge clk_pixel); @(negedge clk_pixel);
        check("cls_we", cpu_write_enable, 0);
        check("cls_busy", busy, 1);
        check("cls_cx", cursor_x, 0);
        cls_req = 1'b0; char_valid = 1'b0;
        n = 0; bad = 0;
        for (int c = 0; c < 6000; c++) begin
            @(negedge clk_pixel);
            if (cpu_write_enable) begin
                if (cpu_addr == ADDR_W'(1000)) break;
                if (cpu_addr !== ADDR_W'(n)) bad++;
                n++;
            end
        end
        check("cls_pre_strobes", n, 1000);
        check("cls_pre_bad", bad, 0);
        check("cls_at_1000", cpu_addr, 1000);
        rst = 1'b1;
        #1;
        check("abort_we", cpu_write_enable, 0);
        check("abort_addr", cpu_addr, 0);
        check("abort_ready", char_ready, 0);
        @(negedge clk_pixel);
        rst = 1'b0;
        drain(0, n, bad, low);
        check("restart_strobes", n, 4800);
        check("restart_bad", bad, 0);

        // Form feed behaves as a clear-screen
        send(8'h43);
        send(FF);
        check("ff_we", cpu_write_enable, 0);
        check("ff_busy", busy, 1);
        check("ff_cx", cursor_x, 0);
        drain(0, n, bad, low);
        check("ff_strobes", n, 4800);
        check("ff_bad", bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
